// File: rtl/instr_word_pkg.sv
// instr_word_pkg: default widths, NOP constants and the fixed-width instruction word
package instr_word_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int OP_W_DEF = 8;
   localparam int ADDR_W_DEF = 24;
   localparam logic [OP_W_DEF-1:0] NOP_OPCODE_DEF = 8'hFF;
   localparam int NOP_A_DEF = 100;
   localparam int NOP_B_DEF = 5;
   typedef struct packed {
      logic [DATA_W_DEF-1:0] a;
      logic [DATA_W_DEF-1:0] b;
      logic [OP_W_DEF-1:0]   opcode;
      logic [ADDR_W_DEF-1:0] address;
   } instruction_word_t;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers, occupancy and handshake qualification for a power-of-two FIFO
module fifo_ptr_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH)-1:0]   wr_ptr,
   output logic [$clog2(DEPTH)-1:0]   rd_ptr,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       push,
   output logic                       pop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   // a flush swallows any handshake in the same cycle
   assign push = in_valid && !full && !flush;
   assign pop = out_ready && !empty && !flush;
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   a_count_max: assert property (@(posedge clock) disable iff (reset) count <= CW'(DEPTH));
   a_no_push_full: assert property (@(posedge clock) disable iff (reset) push |-> !full);
   a_no_pop_empty: assert property (@(posedge clock) disable iff (reset) pop |-> !empty);
endmodule

// File: rtl/instr_word_queue.sv
// instr_word_queue: show-ahead FIFO of instruction words that presents a NOP word while empty
module instr_word_queue
   import instr_word_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W = OP_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH = 4,
   parameter logic [OP_W-1:0] NOP_OPCODE = OP_W'(NOP_OPCODE_DEF),
   parameter int NOP_A = NOP_A_DEF,
   parameter int NOP_B = NOP_B_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_a,
   input  logic [DATA_W-1:0]        in_b,
   input  logic [OP_W-1:0]          in_opcode,
   input  logic [ADDR_W-1:0]        in_address,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_a,
   output logic [DATA_W-1:0]        out_b,
   output logic [OP_W-1:0]          out_opcode,
   output logic [ADDR_W-1:0]        out_address,
   output logic [$clog2(DEPTH):0]   count
);
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   opcode;
      logic [ADDR_W-1:0] address;
   } word_t;
   word_t mem [DEPTH];
   word_t head;
   logic [$clog2(DEPTH)-1:0] wr_ptr, rd_ptr;
   logic full, empty, push, pop;
   fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clock(clock),
      .reset(reset),
      .flush(flush),
      .in_valid(in_valid),
      .out_ready(out_ready),
      .wr_ptr(wr_ptr),
      .rd_ptr(rd_ptr),
      .count(count),
      .full(full),
      .empty(empty),
      .push(push),
      .pop(pop)
   );
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= '{a: in_a, b: in_b, opcode: in_opcode, address: in_address};
   end
   assign in_ready = !full;
   assign out_valid = !empty;
   assign head = mem[rd_ptr];
   // storage is never read while empty, so outputs stay defined after reset
   always_comb begin
      out_a = empty ? DATA_W'(NOP_A) : head.a;
      out_b = empty ? DATA_W'(NOP_B) : head.b;
      out_opcode = empty ? NOP_OPCODE : head.opcode;
      out_address = empty ? '0 : head.address;
   end
   a_pop_valid: assert property (@(posedge clock) disable iff (reset) pop |-> out_valid);
   a_hold: assert property (@(posedge clock) disable iff (reset)
      out_valid && !out_ready && !flush |=> $stable({out_a, out_b, out_opcode, out_address}));
endmodule

// File: tb/tb_instr_word_queue.sv
// tb_instr_word_queue: queue-model checking of the default queue plus directed checks of a narrow deep one
module tb_instr_word_queue;
   logic clock = 0;
   always #5 clock = ~clock;

   logic reset = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic [31:0] in_a = 0, in_b = 0;
   logic [7:0] in_opcode = 0;
   logic [23:0] in_address = 0;
   logic in_ready, out_valid;
   logic [31:0] out_a, out_b;
   logic [7:0] out_opcode;
   logic [23:0] out_address;
   logic [2:0] count;

   logic r2 = 1, f2 = 0, v2 = 0, rdy2 = 0;
   logic [15:0] a2 = 0, b2 = 0;
   logic [3:0] op2 = 0;
   logic [11:0] ad2 = 0;
   logic ir2, ov2;
   logic [15:0] oa2, ob2;
   logic [3:0] oo2;
   logic [11:0] oad2;
   logic [3:0] cnt2;

   instr_word_queue dut (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_address(in_address),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_opcode(out_opcode), .out_address(out_address), .count(count)
   );

   instr_word_queue #(.DATA_W(16), .OP_W(4), .ADDR_W(12), .DEPTH(8)) dut2 (
      .clock(clock), .reset(r2), .flush(f2), .in_valid(v2), .in_ready(ir2),
      .in_a(a2), .in_b(b2), .in_opcode(op2), .in_address(ad2),
      .out_valid(ov2), .out_ready(rdy2), .out_a(oa2), .out_b(ob2),
      .out_opcode(oo2), .out_address(oad2), .count(cnt2)
   );

   int vec = 0, miss = 0;
   bit chk_en = 0;
   logic [95:0] q[$];
   logic [95:0] exp_head;
   bit m_rdy, m_vld;
   localparam logic [95:0] NOP_WORD = {32'd100, 32'd5, 8'hFF, 24'd0};

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // reference: a plain queue of packed words, updated from the sampled handshakes
   always @(posedge clock) begin
      m_rdy = q.size() != 4;
      m_vld = q.size() != 0;
      if (reset || flush) q.delete();
      else begin
         if (out_ready && m_vld) void'(q.pop_front());
         if (in_valid && m_rdy) q.push_back({in_a, in_b, in_opcode, in_address});
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         exp_head = q.size() != 0 ? q[0] : NOP_WORD;
         chk("count", count, q.size());
         chk("in_ready", in_ready, q.size() != 4);
         chk("out_valid", out_valid, q.size() != 0);
         chk("head", {out_a, out_b, out_opcode, out_address}, exp_head);
      end
   end

   task automatic put(input logic [7:0] op);
      in_valid = 1;
      in_opcode = op;
      in_a = {24'h0, op} + 32'h1000;
      in_b = ~{24'h0, op};
      in_address = {16'h0, op} << 4;
   endtask

   logic [47:0] ex [8];

   initial begin
      @(negedge clock);
      chk_en = 1;
      reset = 0;
      repeat (3) @(negedge clock);
      chk("idle_valid", out_valid, 0);
      chk("idle_op", out_opcode, 8'hFF);
      chk("idle_a", out_a, 100);
      chk("idle_b", out_b, 5);
      chk("idle_addr", out_address, 0);
      chk("idle_count", count, 0);
      chk("idle_ready", in_ready, 1);
      // single word round trip
      in_valid = 1; in_a = 1; in_b = 2; in_opcode = 8'h10; in_address = 24'h000100;
      @(negedge clock);
      in_valid = 0;
      chk("one_valid", out_valid, 1);
      chk("one_word", {out_a, out_b, out_opcode, out_address}, {32'd1, 32'd2, 8'h10, 24'h000100});
      out_ready = 1;
      @(negedge clock);
      out_ready = 0;
      chk("one_drain_count", count, 0);
      chk("one_drain_op", out_opcode, 8'hFF);
      // fill to full, then a refused fifth push
      for (int i = 1; i <= 5; i++) begin
         put(8'(i));
         @(negedge clock);
      end
      in_valid = 0;
      chk("full_count", count, 4);
      chk("full_ready", in_ready, 0);
      for (int i = 1; i <= 4; i++) begin
         chk("fill_order", out_opcode, 8'(i));
         out_ready = 1;
         @(negedge clock);
      end
      out_ready = 0;
      chk("fill_empty", count, 0);
      // steady push+pop at count 2 across pointer wrap
      put(8'h20); @(negedge clock);
      put(8'h21); @(negedge clock);
      out_ready = 1;
      for (int k = 0; k < 10; k++) begin
         chk("wrap_count", count, 2);
         chk("wrap_op", out_opcode, 8'(8'h20 + k));
         put(8'(8'h22 + k));
         @(negedge clock);
      end
      out_ready = 0;
      put(8'h2C); @(negedge clock);
      chk("pre_flush_count", count, 3);
      put(8'h2D);
      flush = 1;
      @(negedge clock);
      flush = 0; in_valid = 0;
      chk("flush_count", count, 0);
      chk("flush_valid", out_valid, 0);
      chk("flush_head", {out_a, out_b, out_opcode, out_address}, NOP_WORD);
      chk("flush_ready", in_ready, 1);
      repeat (2) @(negedge clock);
      // reset mid-stream with a push pending
      put(8'h30); @(negedge clock);
      put(8'h31); @(negedge clock);
      put(8'h32);
      reset = 1;
      @(negedge clock);
      reset = 0; in_valid = 0;
      chk("rst_count", count, 0);
      chk("rst_head", {out_a, out_b, out_opcode, out_address}, NOP_WORD);
      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         reset = $urandom_range(0, 199) == 0;
         flush = $urandom_range(0, 39) == 0;
         in_valid = $urandom_range(0, 2) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         in_a = $urandom_range(0, 7) == 0 ? '1 : $urandom;
         in_b = $urandom;
         in_opcode = 8'($urandom);
         in_address = $urandom_range(0, 7) == 0 ? '1 : 24'($urandom);
         @(negedge clock);
      end
      reset = 0; flush = 0; in_valid = 0; out_ready = 1;
      repeat (6) @(negedge clock);
      out_ready = 0;
      // narrow, deep instance
      r2 = 0;
      @(negedge clock);
      chk("n_idle", {oa2, ob2, oo2, oad2}, {16'd100, 16'd5, 4'hF, 12'h0});
      chk("n_idle_count", cnt2, 0);
      ex[0] = '1;
      for (int i = 1; i < 8; i++) ex[i] = {16'($urandom), 16'($urandom), 4'(i), 12'($urandom)};
      for (int i = 0; i < 9; i++) begin
         v2 = 1;
         {a2, b2, op2, ad2} = i < 8 ? ex[i] : 48'h0;
         @(negedge clock);
      end
      v2 = 0;
      chk("n_full_count", cnt2, 8);
      chk("n_full_ready", ir2, 0);
      for (int i = 0; i < 8; i++) begin
         chk("n_word", {ov2, oa2, ob2, oo2, oad2}, {1'b1, ex[i]});
         rdy2 = 1;
         @(negedge clock);
      end
      rdy2 = 0;
      chk("n_drain", {cnt2, oa2, ob2, oo2, oad2}, {4'd0, 16'd100, 16'd5, 4'hF, 12'h0});
      v2 = 1; {a2, b2, op2, ad2} = ex[0];
      repeat (2) @(negedge clock);
      r2 = 1;
      @(negedge clock);
      r2 = 0; v2 = 0;
      chk("n_rst", {ov2, cnt2}, 5'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
